// File: rtl/mrc_std_lane_aligner_if.sv
// rtl/mrc_std_lane_aligner_if.sv - per-lane input streams and aligned output stream of the lane aligner
interface mrc_std_lane_aligner_if #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_LANES-1:0]            in_valid;
    logic [2*NUM_LANES-1:0]          in_cntl;
    logic [DATA_WIDTH*NUM_LANES-1:0] in_data;
    logic [NUM_LANES-1:0]            in_ready;
    logic                            out_valid;
    logic [1:0]                      out_cntl;
    logic [DATA_WIDTH*NUM_LANES-1:0] out_data;
    logic                            out_ready;

    modport master (
        output in_valid, in_cntl, in_data, out_ready,
        input  in_ready, out_valid, out_cntl, out_data
    );

    modport slave (
        input  in_valid, in_cntl, in_data, out_ready,
        output in_ready, out_valid, out_cntl, out_data
    );
endinterface

// File: rtl/mrc_std_lane_aligner.sv
// rtl/mrc_std_lane_aligner.sv - per-lane FIFOs merged into lockstep beats with SOM/MOM/EOM framing check
// Optional skew timeout enabled by defining MRC_STD_LANE_ALIGNER_SKEW_TIMEOUT_EN.
module mrc_std_lane_aligner #(
    parameter int NUM_LANES      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset_poweron_n,
    input  logic [NUM_LANES-1:0] lane_enable,
    input  logic                 clear_err,
    output logic                 framing_err,
    output logic [15:0]          pkt_count,
    output logic                 skew_timeout,
    mrc_std_lane_aligner_if.slave bus
);
    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]  MOM     = 2'b00;
    localparam logic [1:0]  SOM     = 2'b01;
    localparam logic [1:0]  EOM     = 2'b10;
    localparam logic [1:0]  SOM_EOM = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_ERR} state_t;

    state_t                          state;
    logic [NUM_LANES-1:0]            active;
    logic [1:0]                      mem_cntl [NUM_LANES][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]           mem_data [NUM_LANES][FIFO_DEPTH];
    logic [AW:0]                     wr_ptr   [NUM_LANES];
    logic [AW:0]                     rd_ptr   [NUM_LANES];
    logic [NUM_LANES-1:0]            full;
    logic [NUM_LANES-1:0]            empty;
    logic [NUM_LANES-1:0]            ready;
    logic [NUM_LANES-1:0]            push;
    logic [1:0]                      ref_cntl;
    logic                            mismatch;
    logic [DATA_WIDTH*NUM_LANES-1:0] head_data;
    logic                            aligned;
    logic                            load_ok;
    logic                            legal;
    logic                            pop;
    logic                            frame_bad;
    logic                            skew_hit;

    logic                            out_valid_q;
    logic [1:0]                      out_cntl_q;
    logic [DATA_WIDTH*NUM_LANES-1:0] out_data_q;

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_cntl  = out_cntl_q;
    assign bus.out_data  = out_data_q;

    always_comb begin
        full      = '0;
        empty     = '0;
        ready     = '0;
        push      = '0;
        head_data = '0;
        ref_cntl  = MOM;
        mismatch  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            full[i]  = (wr_ptr[i] - rd_ptr[i]) == DEPTH;
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            // Disabled lanes and the whole ERR state sink input unconditionally.
            ready[i] = (state == S_ERR) || !active[i] || !full[i];
            push[i]  = bus.in_valid[i] && ready[i] && active[i] && (state != S_ERR);
            if (active[i])
                head_data[DATA_WIDTH*i +: DATA_WIDTH] = mem_data[i][rd_ptr[i][AW-1:0]];
        end
        // Descending scan leaves the lowest-index active lane as the reference.
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (active[i])
                ref_cntl = mem_cntl[i][rd_ptr[i][AW-1:0]];
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            if (active[i] && (mem_cntl[i][rd_ptr[i][AW-1:0]] != ref_cntl))
                mismatch = 1'b1;
        end
    end

    assign aligned   = (|active) && ((active & empty) == '0);
    assign load_ok   = !out_valid_q || bus.out_ready;
    assign legal     = (state == S_IDLE) ? (ref_cntl == SOM || ref_cntl == SOM_EOM)
                                         : (ref_cntl == MOM || ref_cntl == EOM);
    assign frame_bad = (state != S_ERR) && aligned && (mismatch || (load_ok && !legal));
    assign pop       = (state != S_ERR) && aligned && !mismatch && legal && load_ok;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push[i]) begin
                mem_cntl[i][wr_ptr[i][AW-1:0]] <= bus.in_cntl[2*i +: 2];
                mem_data[i][wr_ptr[i][AW-1:0]] <= bus.in_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (state == S_ERR) begin
                    rd_ptr[i] <= wr_ptr[i];
                end else begin
                    if (push[i])
                        wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    if (pop && active[i])
                        rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            state       <= S_IDLE;
            active      <= '1;
            out_valid_q <= 1'b0;
            out_cntl_q  <= 2'b00;
            out_data_q  <= '0;
            framing_err <= 1'b0;
            pkt_count   <= 16'd0;
        end else begin
            // A held beat retires on handshake in every state, ERR included.
            if (out_valid_q && bus.out_ready)
                out_valid_q <= 1'b0;
            if (state == S_ERR) begin
                if (clear_err) begin
                    framing_err <= 1'b0;
                    state       <= S_IDLE;
                end
            end else begin
                if (clear_err)
                    framing_err <= 1'b0;
                if (frame_bad) begin
                    framing_err <= 1'b1;
                    state       <= S_ERR;
                end else if (skew_hit) begin
                    state <= S_ERR;
                end else if (pop) begin
                    out_valid_q <= 1'b1;
                    out_cntl_q  <= ref_cntl;
                    out_data_q  <= head_data;
                    case (ref_cntl)
                        SOM:     state <= S_STREAM;
                        SOM_EOM: pkt_count <= pkt_count + 16'd1;
                        EOM: begin
                            pkt_count <= pkt_count + 16'd1;
                            state     <= S_IDLE;
                        end
                        default: ;
                    endcase
                end
                if (state == S_IDLE && !pop)
                    active <= lane_enable;
            end
        end
    end

`ifdef MRC_STD_LANE_ALIGNER_SKEW_TIMEOUT_EN
    logic [15:0] skew_cnt;
    logic        skew_cond;

    assign skew_cond = (|(active & ~empty)) && ((active & empty) != '0);
    assign skew_hit  = (state != S_ERR) && skew_cond && ((skew_cnt + 16'd1) == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            skew_cnt     <= 16'd0;
            skew_timeout <= 1'b0;
        end else begin
            skew_cnt <= (skew_cond && (state != S_ERR) && !skew_hit) ? skew_cnt + 16'd1 : 16'd0;
            if (skew_hit)
                skew_timeout <= 1'b1;
            else if (clear_err)
                skew_timeout <= 1'b0;
        end
    end
`else
    assign skew_hit     = 1'b0;
    assign skew_timeout = 1'b0;
`endif

endmodule

// File: doc/mrc_std_lane_aligner.md
Name: mrc_std_lane_aligner

Overview:
- Parametrised successor to the single-lane MRC→stack-down stream path.
- Accepts NUM_LANES independent valid/ready/cntl/data lane streams from the memory read controller and buffers each lane in its own FIFO.
- Issues one lockstep, lane-aligned beat towards stack-down only when every enabled lane has a head entry.
- Checks SOM/MOM/EOM framing consistency across lanes and over time, and holds off on framing errors.

Parameters:
- NUM_LANES, 4: number of execution lanes (1..32).
- DATA_WIDTH, 32: per-lane data width.
- FIFO_DEPTH, 4: entries per lane FIFO; power of 2, ≥2.
- TIMEOUT_CYCLES, 255: skew timeout; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset_poweron_n  in  1  asynchronous active-low reset
- lane_enable  in  NUM_LANES  lane mask; sampled only in IDLE
- in_valid  in  NUM_LANES  per-lane valid
- in_cntl  in  2*NUM_LANES  per-lane cntl; lane i at [2i+1:2i]
- in_data  in  DATA_WIDTH*NUM_LANES  per-lane data
- in_ready  out  NUM_LANES  per-lane ready
- out_valid  out  1  aligned beat valid
- out_cntl  out  2  aligned beat cntl
- out_data  out  DATA_WIDTH*NUM_LANES  aligned data; disabled lanes driven 0
- out_ready  in  1  downstream ready
- framing_err  out  1  sticky error flag
- clear_err  in  1  single-cycle pulse; clears error, exits ERR
- pkt_count  out  16  completed packets (EOM or SOM_EOM beats issued); wraps at 0xFFFF→0
- skew_timeout  out  1  sticky; functional only with the optional feature

Behaviour:
- Reset values: all FIFOs empty; state IDLE; active mask = all 1s; out_valid=0; out_cntl=0; out_data=0; framing_err=0; skew_timeout=0; pkt_count=0. in_ready is combinational and becomes 1 on any non-full lane once reset deasserts.
- Cntl encoding: MOM=2'b00, SOM=2'b01, EOM=2'b10, SOM_EOM=2'b11.
- Enqueue: lane i pushes when in_valid[i] && in_ready[i].
  - in_ready[i] = !full[i] in IDLE/STREAM.
  - A lane disabled in the active mask has in_ready[i]=1 and its data is discarded, never enqueued.
  - in_ready is 1 on every lane in ERR.
- Aligned condition: every active lane's FIFO is non-empty.
  - No lane enabled: never aligned; out_valid stays 0.
- Output register stage:
  - Minimum latency is 2 cycles from the last lane's push to out_valid=1.
  - The output register reloads when out_valid=0 or out_ready=1, giving full throughput with a skid-free pop.
- Loading the output register pops all active FIFO heads simultaneously.
  - out_cntl is taken from the lowest-index active lane.
  - out_data holds all head data; disabled lanes are 0.
  - out_valid/out_cntl/out_data hold stable while out_valid && !out_ready.
- Simultaneous push and pop on a full FIFO: the pop frees the slot only in the next cycle; in_ready uses the current full flag.
- Cross-lane check: if the active heads' cntl values differ when aligned, no pop occurs, framing_err is set, and the state goes to ERR.
- FSM (evaluated on an aligned, accepted pop):
  - IDLE, SOM → issue beat, go STREAM.
  - IDLE, SOM_EOM → issue beat, pkt_count+1, stay IDLE.
  - IDLE, MOM or EOM → no beat, framing_err, go ERR.
  - STREAM, MOM → issue beat, stay.
  - STREAM, EOM → issue beat, pkt_count+1, go IDLE.
  - STREAM, SOM or SOM_EOM → no beat, framing_err, go ERR.
  - ERR → every cycle, flush all FIFOs (empty) and discard input. An already-loaded output beat still completes its handshake. On clear_err: framing_err=0, go IDLE.
  - clear_err outside ERR: clears the sticky flags only.
- lane_enable is latched into the active mask on every IDLE cycle with no pop. A change during STREAM takes effect at the next IDLE.
- Asserting reset mid-packet returns every register to its reset value immediately; partial packets are lost.

Optional Feature:
- Macro: MRC_STD_LANE_ALIGNER_SKEW_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit skew counter increments each cycle in which at least one, but not all, active lanes are non-empty; it resets to 0 otherwise.
  - When the counter reaches TIMEOUT_CYCLES, skew_timeout is set (sticky, cleared by clear_err) and the state goes to ERR. framing_err is not set.
- Without the macro: no counter is instantiated; skew_timeout is tied to 0.

Test Plan:
- NUM_LANES=4, all enabled, 3-beat packet (SOM, MOM, EOM; data lane i = 0x10*beat+i) with lanes arriving 0..3 cycles skewed, out_ready=1 → 3 out_valid beats; out_data lanes match; out_cntl 01,00,10; pkt_count=1.
- lane_enable=4'b0101, single SOM_EOM beat on all lanes → one beat; lanes 1,3 out_data=0; in_ready[1]=in_ready[3]=1; pkt_count=1.
- out_ready=0 with 5 beats pushed per lane, FIFO_DEPTH=4 → in_ready drops to 0 once each FIFO is full plus the output register; out_data stable; releasing out_ready drains all 5 in order.
- Lane 2 sends MOM while the others send SOM in IDLE → framing_err=1, out_valid stays 0, in_ready=4'hF; clear_err → IDLE; next good packet passes.
- EOM received in IDLE → framing_err=1, ERR; asynchronous reset asserted mid-STREAM → all outputs return to reset values within the same cycle.
- With the macro, TIMEOUT_CYCLES=8, only lane 0 fed → skew_timeout=1 after 8 cycles and FIFOs flushed; without the macro, skew_timeout stays 0 indefinitely.
